vscale_dmem_responder: RTL and testbench
========================================

VSCALE_DMEM_RESPONDER -- requirements
Module: vscale_dmem_responder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
- DEPTH_WORDS, 1024, number of 32-bit words in the memory array.
- BASE_ADDR, 32'h0, byte address of word 0.
- WAIT_CYCLES, 0, data-phase wait states per access, legal range 0..15.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
- clk, in, 1, clock, rising edge.
- reset, in, 1, synchronous, active-high.
- dmem_en, in, 1, address-phase request.
- dmem_wen, in, 1, 1 = store, 0 = load.
- dmem_size, in, 3, bits [1:0]: 0 = byte, 1 = half, 2 = word; bit 2 (unsigned) is ignored.
- dmem_addr, in, 32, byte address.
- dmem_wdata_delayed, in, 32, store data driven in the data phase, lanes pre-replicated.
- dmem_rdata, out, 32, aligned load word.
- dmem_wait, out, 1, data phase not complete.
- dmem_badmem_e, out, 1, access error, valid in the completion cycle.
- err_count, out, 16, saturating count of errored accesses.

Function
REQ-003 Address-phase accept SHALL occur when dmem_en=1 and dmem_wait=0; the block SHALL then register wen, size, addr and set dphase_valid=1 and wait counter cnt=WAIT_CYCLES.
REQ-004 dmem_en SHALL be ignored while dmem_wait=1; the initiator holds its request until wait drops.
REQ-005 dmem_wait SHALL equal dphase_valid AND (cnt != 0), driven from registers only.
REQ-006 In a data-phase cycle with cnt != 0, cnt SHALL decrement by 1.
REQ-007 The completion cycle SHALL be the cycle with dphase_valid=1 and cnt=0. It occurs WAIT_CYCLES+1 cycles after accept, so WAIT_CYCLES=0 gives completion in the cycle immediately after accept.
REQ-008 In the completion cycle, if no new accept occurs, dphase_valid SHALL clear at the next edge. A new accept in the same cycle SHALL keep dphase_valid=1 and reload cnt, giving back-to-back throughput of one access per WAIT_CYCLES+1 cycles.
REQ-009 An error SHALL be flagged for the captured access if any of the following holds:
- (addr - BASE_ADDR) >= 4*DEPTH_WORDS, with unsigned 32-bit wrap.
- size is half and addr[0]=1.
- size is word and addr[1:0] != 0.
- size[1:0] = 3.
REQ-010 dmem_badmem_e SHALL be 1 only in a completion cycle whose access is flagged; otherwise it SHALL be 0.
REQ-011 Store byte enables SHALL be:
- byte: 4'b0001 << addr[1:0].
- half: 4'b0011 << {addr[1],1'b0}.
- word: 4'b1111.
REQ-012 A non-error store SHALL write the enabled lanes of dmem_wdata_delayed into word (addr - BASE_ADDR) >> 2 at the clock edge ending the completion cycle; unenabled lanes SHALL be preserved.
REQ-013 An errored store SHALL not modify memory.
REQ-014 In the completion cycle of a non-error load, dmem_rdata SHALL equal the full stored word at the aligned address; the initiator performs lane shifting and extension.
REQ-015 dmem_rdata SHALL be 0 in all other cycles, and in the completion cycle of a store or an errored load.
REQ-016 A load accepted in the completion cycle of a store to the same word SHALL return the post-store contents.
REQ-017 err_count SHALL increment by 1 at the edge ending each errored completion cycle and SHALL saturate at 16'hFFFF.

Reset
REQ-018 While reset=1 at a rising edge:
- dphase_valid, cnt and err_count SHALL clear to 0.
- dmem_wait, dmem_badmem_e and dmem_rdata SHALL read 0 in the following cycle.
REQ-019 Reset asserted during a data phase SHALL abandon the access with no memory write and no err_count update.
REQ-020 Memory contents SHALL not be initialised by reset.
REQ-021 dmem_en asserted in the same cycle as reset SHALL not be accepted.

Verification
REQ-022 WAIT_CYCLES=0: store word 32'hDEADBEEF to 0x10, then load 0x10 back-to-back. Required response: dmem_wait never 1; load completion cycle shows dmem_rdata=32'hDEADBEEF.
REQ-023 WAIT_CYCLES=3: load 0x0. Required response: dmem_wait=1 for exactly 3 cycles after accept, then one completion cycle with dmem_wait=0 and valid rdata.
REQ-024 Word at 0x20 = 32'h11223344; store byte 8'hAA (wdata 32'hAAAAAAAA) to 0x22, then load 0x20. Required response: rdata=32'h11AA3344.
REQ-025 Error cases:
- Load word at 0x2: dmem_badmem_e=1, rdata=0, err_count=1.
- Store beyond 4*DEPTH_WORDS: badmem_e=1, memory unchanged, err_count=2.
REQ-026 WAIT_CYCLES=2: store to 0x40, assert reset during the wait cycles. Required response: outputs read 0 the following cycle, a later load of 0x40 returns the pre-store value, err_count=0.

Source files
------------

// File: rtl/vscale_dmem_responder.sv
// Data-memory slave for the vscale pipeline: accepts one address phase at a time,
// inserts WAIT_CYCLES data-phase wait states, then completes with load data or an error.
module vscale_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_en,
  input  logic        dmem_wen,
  input  logic [2:0]  dmem_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata_delayed,
  output logic [31:0] dmem_rdata,
  output logic        dmem_wait,
  output logic        dmem_badmem_e,
  output logic [15:0] err_count
);

  localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_CYCLES);

  logic        dphase_valid_q, dphase_valid_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wen_q, wen_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] err_count_q, err_count_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic             accept;
  logic             complete;
  logic             access_err;
  logic             mem_we;
  logic [31:0]      offset;
  logic [IDX_W-1:0] word_idx;
  logic [3:0]       byte_en;
  logic             unused_size_bit;

  // Signedness bit of the size field only matters to the initiator's extension logic.
  assign unused_size_bit = dmem_size[2];

  assign dmem_wait = dphase_valid_q & (cnt_q != 4'd0);
  assign complete  = dphase_valid_q & (cnt_q == 4'd0);
  assign accept    = dmem_en & ~dmem_wait;

  // Offset wraps unsigned, so addresses below BASE_ADDR land far out of range.
  assign offset     = addr_q - BASE_ADDR;
  assign word_idx   = IDX_W'(offset >> 2);
  assign access_err = (offset >= SPAN_BYTES)
                    | ((size_q == 2'd1) & addr_q[0])
                    | ((size_q == 2'd2) & (addr_q[1:0] != 2'b00))
                    | (size_q == 2'd3);

  always_comb begin
    byte_en = 4'b1111;
    case (size_q)
      2'd0:    byte_en = 4'b0001 << addr_q[1:0];
      2'd1:    byte_en = 4'b0011 << {addr_q[1], 1'b0};
      default: byte_en = 4'b1111;
    endcase
  end

  assign mem_we        = complete & wen_q & ~access_err & ~reset;
  assign dmem_badmem_e = complete & access_err;
  assign dmem_rdata    = (complete & ~wen_q & ~access_err) ? mem_q[word_idx] : 32'h0;
  assign err_count     = err_count_q;

  always_comb begin
    dphase_valid_d = dphase_valid_q;
    cnt_d          = cnt_q;
    wen_d          = wen_q;
    size_d         = size_q;
    addr_d         = addr_q;
    err_count_d    = err_count_q;

    if (complete && access_err && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end

    // A completion cycle may overlap a new accept, which reloads the counter.
    if (accept) begin
      dphase_valid_d = 1'b1;
      cnt_d          = WAIT_LOAD;
      wen_d          = dmem_wen;
      size_d         = dmem_size[1:0];
      addr_d         = dmem_addr;
    end else if (dmem_wait) begin
      cnt_d = cnt_q - 4'd1;
    end else if (complete) begin
      dphase_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dphase_valid_q <= 1'b0;
      cnt_q          <= 4'd0;
      err_count_q    <= 16'd0;
    end else begin
      dphase_valid_q <= dphase_valid_d;
      cnt_q          <= cnt_d;
      err_count_q    <= err_count_d;
    end
  end

  always_ff @(posedge clk) begin
    wen_q  <= wen_d;
    size_q <= size_d;
    addr_q <= addr_d;
  end

  // Memory array has no reset; only enabled lanes of a clean store are written.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem_q[word_idx][8*i +: 8] <= dmem_wdata_delayed[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// Self-checking bench for vscale_dmem_responder: three instances with different
// wait-state and base settings, checked every cycle against a scoreboard model.
module tb_vscale_dmem_responder;

  localparam int          WAITS [3] = '{0, 3, 2};
  localparam logic [31:0] BASES [3] = '{32'h0, 32'h0, 32'h200};

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        en_i    [3];
  logic        wen_i   [3];
  logic [2:0]  size_i  [3];
  logic [31:0] addr_i  [3];
  logic [31:0] wdata_i [3];
  logic [31:0] rdata_o [3];
  logic        dwait_o [3];
  logic        bad_o   [3];
  logic [15:0] errc_o  [3];

  exp_t        sb [3][$];
  logic [31:0] mm [3][64];
  bit          mv [3];
  int          mc [3];
  logic [15:0] mec [3];
  bit          last_err [3];
  bit          checking;
  int          n_compared;
  int          n_mismatch;

  for (genvar g = 0; g < 3; g++) begin : g_unit
    vscale_dmem_responder #(
      .DEPTH_WORDS(64),
      .BASE_ADDR(BASES[g]),
      .WAIT_CYCLES(WAITS[g])
    ) dut (
      .clk(clk),
      .reset(reset),
      .dmem_en(en_i[g]),
      .dmem_wen(wen_i[g]),
      .dmem_size(size_i[g]),
      .dmem_addr(addr_i[g]),
      .dmem_wdata_delayed(wdata_i[g]),
      .dmem_rdata(rdata_o[g]),
      .dmem_wait(dwait_o[g]),
      .dmem_badmem_e(bad_o[g]),
      .err_count(errc_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_compared++;
    if (obs !== expv) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got %h, want %h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Protocol timing model: accept, wait countdown, completion, saturating error count.
  always @(posedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (reset) begin
        mv[u]  <= 1'b0;
        mc[u]  <= 0;
        mec[u] <= 16'd0;
        sb[u].delete();
      end else begin
        if (mv[u] && mc[u] == 0 && last_err[u] && mec[u] != 16'hFFFF) mec[u] <= mec[u] + 16'd1;
        if (en_i[u] && !(mv[u] && mc[u] != 0)) begin
          mv[u] <= 1'b1;
          mc[u] <= WAITS[u];
        end else if (mv[u] && mc[u] != 0) begin
          mc[u] <= mc[u] - 1;
        end else if (mv[u]) begin
          mv[u] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (checking) begin
      for (int u = 0; u < 3; u++) begin
        checkOutput($sformatf("wait_u%0d", u), {31'b0, dwait_o[u]}, {31'b0, (mv[u] && mc[u] != 0)});
        checkOutput($sformatf("errcnt_u%0d", u), {16'b0, errc_o[u]}, {16'b0, mec[u]});
        if (mv[u] && mc[u] == 0) begin
          if (sb[u].size() == 0) begin
            checkOutput($sformatf("sb_underflow_u%0d", u), sb[u].size(), 1);
            last_err[u] <= 1'b0;
          end else begin
            e = sb[u].pop_front();
            checkOutput($sformatf("badmem_u%0d", u), {31'b0, bad_o[u]}, {31'b0, e.err});
            checkOutput($sformatf("rdata_u%0d", u), rdata_o[u], e.rdata);
            last_err[u] <= e.err;
          end
        end else begin
          checkOutput($sformatf("idle_badmem_u%0d", u), {31'b0, bad_o[u]}, 32'h0);
          checkOutput($sformatf("idle_rdata_u%0d", u), rdata_o[u], 32'h0);
          last_err[u] <= 1'b0;
        end
      end
    end
  end

  // Issue one access from a negedge; returns at the negedge of its completion cycle
  // (or right after accept when stop_early is set, leaving the store unapplied).
  task automatic applyStimulus(input int u, input bit w, input logic [2:0] sz,
                               input logic [31:0] a, input logic [31:0] d, input bit stop_early);
    exp_t        e;
    logic [31:0] off;
    logic [3:0]  be;
    bit          err;
    off = a - BASES[u];
    err = (off >= 32'd256) || (sz[1:0] == 2'd1 && a[0]) ||
          (sz[1:0] == 2'd2 && a[1:0] != 2'b00) || (sz[1:0] == 2'd3);
    case (sz[1:0])
      2'd0:    be = 4'b0001 << a[1:0];
      2'd1:    be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    if (!err && w && !stop_early) begin
      for (int i = 0; i < 4; i++) if (be[i]) mm[u][off[7:2]][8*i +: 8] = d[8*i +: 8];
    end
    e.err   = err;
    e.rdata = (!err && !w) ? mm[u][off[7:2]] : 32'h0;
    sb[u].push_back(e);
    en_i[u]   = 1'b1;
    wen_i[u]  = w;
    size_i[u] = sz;
    addr_i[u] = a;
    @(posedge clk);
    #1;
    en_i[u]    = 1'b0;
    wdata_i[u] = d;
    if (!stop_early) repeat (WAITS[u]) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_compared = 0;
    n_mismatch = 0;
    checking   = 1'b0;
    reset      = 1'b1;
    for (int u = 0; u < 3; u++) begin
      en_i[u] = 1'b0; wen_i[u] = 1'b0; size_i[u] = 3'd2;
      addr_i[u] = 32'h0; wdata_i[u] = 32'h0; last_err[u] = 1'b0;
    end
    // Request held during reset must not be accepted.
    en_i[1] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checking = 1'b1;
    @(negedge clk);
    en_i[1] = 1'b0;
    reset   = 1'b0;
    idleCycles(1);

    // Unit 2: wait=2, base 0x200; reset abandons an in-flight store.
    applyStimulus(2, 1'b1, 3'd2, 32'h240, 32'h0BADF00D, 1'b0);
    idleCycles(1);
    applyStimulus(2, 1'b1, 3'd2, 32'h240, 32'h12345678, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idleCycles(1);
    applyStimulus(2, 1'b0, 3'd2, 32'h240, 32'h0, 1'b0);
    idleCycles(1);
    checkOutput("rst_errcnt", {16'b0, errc_o[2]}, 32'd0);
    applyStimulus(2, 1'b0, 3'd2, 32'h1FC, 32'h0, 1'b0);
    applyStimulus(2, 1'b1, 3'd2, 32'h2FC, 32'h77777777, 1'b0);
    applyStimulus(2, 1'b0, 3'd2, 32'h2FC, 32'h0, 1'b0);
    applyStimulus(2, 1'b1, 3'd2, 32'h300, 32'h66666666, 1'b0);
    idleCycles(2);

    // Unit 0: wait=0, back-to-back traffic, lane merges and error cases.
    applyStimulus(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0);
    applyStimulus(0, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 3'd2, 32'h20, 32'h11223344, 1'b0);
    applyStimulus(0, 1'b1, 3'd0, 32'h22, 32'hAAAAAAAA, 1'b0);
    applyStimulus(0, 1'b0, 3'd2, 32'h20, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 3'd2, 32'h24, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 3'd1, 32'h26, 32'h55665566, 1'b0);
    applyStimulus(0, 1'b0, 3'd2, 32'h24, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 3'd1, 32'h24, 32'h99889988, 1'b0);
    applyStimulus(0, 1'b0, 3'd2, 32'h24, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 3'd2, 32'h0, 32'hCAFEF00D, 1'b0);
    idleCycles(1);
    applyStimulus(0, 1'b0, 3'd2, 32'h2, 32'h0, 1'b0);
    idleCycles(1);
    checkOutput("errcnt_first", {16'b0, errc_o[0]}, 32'd1);
    applyStimulus(0, 1'b1, 3'd2, 32'h100, 32'h13579BDF, 1'b0);
    idleCycles(1);
    checkOutput("errcnt_second", {16'b0, errc_o[0]}, 32'd2);
    applyStimulus(0, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 3'd2, 32'h12, 32'hFFFFFFFF, 1'b0);
    applyStimulus(0, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 3'd1, 32'h21, 32'hBBBBBBBB, 1'b0);
    applyStimulus(0, 1'b0, 3'd3, 32'h0, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 3'd2, 32'hFC, 32'hA5A5A5A5, 1'b0);
    applyStimulus(0, 1'b0, 3'd2, 32'hFC, 32'h0, 1'b0);
    idleCycles(1);
    checkOutput("errcnt_fifth", {16'b0, errc_o[0]}, 32'd5);
    idleCycles(1);

    // Unit 1: wait=3, back-to-back with wait states, unsigned-size bit ignored.
    applyStimulus(1, 1'b1, 3'd2, 32'h0, 32'h01020304, 1'b0);
    applyStimulus(1, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0);
    applyStimulus(1, 1'b0, 3'd4, 32'h3, 32'h0, 1'b0);
    applyStimulus(1, 1'b1, 3'd0, 32'h1, 32'hEEEEEEEE, 1'b0);
    applyStimulus(1, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0);
    applyStimulus(1, 1'b0, 3'd3, 32'h4, 32'h0, 1'b0);
    idleCycles(3);

    for (int u = 0; u < 3; u++) checkOutput($sformatf("sb_left_u%0d", u), sb[u].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
